neuron_layer_engine: RTL
========================

// Module: neuron_layer_engine
// PURPOSE
//  Parametrised successor to the single-neuron MAC unit: computes M neurons in parallel over one
//  shared input vector of length D, y[m] = act(sum_i x[i]*w[m][i] + bias[m]). Signed fixed point.
//  Sits between the input/weight memories and the next layer; one start/done transaction per vector.
// PARAMETERS
//  N   16  data width (signed, two's complement) of x, w, bias, y
//  F    8  fractional bits of every N-bit operand and result
//  D    8  input vector length (>=1); number of MAC steps
//  M    4  neurons (lanes) evaluated in parallel
//  AW  $clog2(D) (min 1)  memory address width
// PORTS
//  clk       in   1     clock, rising edge
//  rst       in   1     reset, asynchronous, active-low (rst==0 resets)
//  start     in   1     request a layer evaluation; sampled only in IDLE
//  act_sel   in   2     activation: 0 identity(sat), 1 ReLU, 2 step, 3 reserved = identity
//  bias      in   M*N   per-lane bias, lane m at [m*N +: N]; sampled on start accept
//  mem_rd    out  1     read strobe to x and weight memories
//  mem_addr  out  AW    element index i, 0..D-1
//  x_data    in   N     x[mem_addr], valid exactly 1 cycle after mem_rd
//  w_data    in   M*N   w[m][mem_addr] per lane, same timing as x_data
//  busy      out  1     high from cycle after start accept until done cycle inclusive
//  done      out  1     one-cycle pulse; y valid from this cycle
//  y         out  M*N   results, held until next done
// BEHAVIOUR
//  - Reset: state IDLE; mem_rd, mem_addr, busy, done, y, accumulators, latched bias/act_sel = 0.
//  - FSM IDLE -> FETCH -> DRAIN -> ACT -> DONE -> IDLE.
//    IDLE: start=1 accepts (cycle 0): clear accumulators, latch bias and act_sel.
//    FETCH: cycles 1..D, mem_rd=1, mem_addr=0..D-1 ascending; leave after addr D-1.
//    DRAIN: cycle D+1, accumulates final data word; mem_rd=0.
//    ACT: cycle D+2, bias add, round, saturate, activation; register into y.
//    DONE: cycle D+3, done=1, busy=1; next cycle IDLE.
//  - Latency start-accept to done = D+3 cycles. Back-to-back: start in the cycle after done.
//  - Accumulate every cycle a read returns (cycles 2..D+1): acc += x_data*w_data[m], full 2N-bit
//    signed product; acc width 2N+$clog2(D)+1, never overflows.
//  - Post-process: s = acc + (bias<<F); r = (s + 2^(F-1)) >>> F (round half up, arithmetic);
//    saturate r to [-2^(N-1), 2^(N-1)-1].
//  - Activation on saturated r: identity -> r; ReLU -> max(r,0); step -> (r>0 ? 1.0 (1<<F) : 0).
//  - start while busy ignored (no queueing); start level held high restarts right after DONE.
//  - Changes to bias/act_sel during busy have no effect on the running transaction.
//  - Async reset mid-operation: immediate return to reset values; no done for aborted run;
//    y cleared to 0.
//  - D=1: single FETCH cycle, latency 4.
// STRUCTURE
//  - Shared package neuron_pkg: activation encodings (ACT_ID, ACT_RELU, ACT_STEP), FSM state
//    typedef, acc-width function, sat/round function (reused by future layers).
//  - Sub-module neuron_mac_lane (one per lane, generate loop): accumulator, bias/round/sat,
//    activation. Top holds FSM, address counter, handshake.
// TESTING (N=16, F=8, D=4, M=2 unless stated)
//  - x=0x0100 all, w0=0x0080, w1=0xFF00, bias=0, act=0 -> y0=0x0200, y1=0xFC00; done at cycle 7.
//  - Same data, act=1 -> y0=0x0200, y1=0x0000; act=2 -> y0=0x0100, y1=0x0000.
//  - x=0x7F00, w0=0x7F00, w1=0x8100 all -> y0=0x7FFF, y1=0x8000 (saturation).
//  - Rounding: x0=0x0001, w0=0x0080, other elements 0, bias0=0x0001 -> y0=0x0002.
//  - start pulsed again at cycles 2 and 5 -> ignored; single done at cycle 7; mem_addr 0,1,2,3.
//  - rst low at cycle 3 then released; next start -> full fresh run, no stale done, y correct.

Source files
------------

// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared encodings, FSM states and fixed-point helpers for neuron layers
package neuron_pkg;

   localparam logic [1:0] ACT_ID   = 2'd0;
   localparam logic [1:0] ACT_RELU = 2'd1;
   localparam logic [1:0] ACT_STEP = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_ACT,
      S_DONE
   } state_t;

   // Accumulator sized so D full-width products plus sign can never overflow.
   function automatic int acc_width(input int n, input int d);
      return 2 * n + $clog2(d) + 1;
   endfunction

   // Round half up by dropping f fraction bits, then clamp to the signed n-bit range.
   function automatic logic signed [63:0] round_sat(input logic signed [63:0] s,
                                                    input int n, input int f);
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r  = (s + (64'sd1 <<< (f - 1))) >>> f;
      hi = (64'sd1 <<< (n - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (n - 1));
      if (r > hi)
         return hi;
      else if (r < lo)
         return lo;
      else
         return r;
   endfunction

endpackage

// File: rtl/neuron_mac_lane.sv
// rtl/neuron_mac_lane.sv - one neuron: MAC accumulator, bias/round/saturate, activation
module neuron_mac_lane
   import neuron_pkg::*;
#(
   parameter int N = 16,
   parameter int F = 8,
   parameter int D = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         acc_en,
   input  logic         act_en,
   input  logic [1:0]   act_sel,
   input  logic [N-1:0] bias_in,
   input  logic [N-1:0] x_data,
   input  logic [N-1:0] w_data,
   output logic [N-1:0] y
);

   localparam int ACC_W = acc_width(N, D);

   logic signed [ACC_W-1:0] acc;
   logic signed [N-1:0]     bias_q;
   logic signed [2*N-1:0]   prod;
   logic signed [63:0]      sum;
   logic signed [63:0]      r64;
   logic signed [N-1:0]     act_v;

   assign prod = (2*N)'($signed(x_data)) * (2*N)'($signed(w_data));
   assign sum  = 64'(acc) + (64'(bias_q) <<< F);
   assign r64  = round_sat(sum, N, F);

   always_comb begin
      act_v = r64[N-1:0];
      case (act_sel)
         ACT_RELU: if (r64 < 64'sd0) act_v = '0;
         ACT_STEP: act_v = (r64 > 64'sd0) ? N'(1 <<< F) : '0;
         default:  act_v = r64[N-1:0];
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc    <= '0;
         bias_q <= '0;
         y      <= '0;
      end else begin
         if (load) begin
            acc    <= '0;
            bias_q <= $signed(bias_in);
         end else if (acc_en) begin
            acc <= acc + ACC_W'(prod);
         end
         if (act_en)
            y <= act_v;
      end
   end

endmodule

// File: rtl/neuron_layer_engine.sv
// rtl/neuron_layer_engine.sv - M parallel neurons over a shared D-element input vector
module neuron_layer_engine
   import neuron_pkg::*;
#(
   parameter int N  = 16,
   parameter int F  = 8,
   parameter int D  = 8,
   parameter int M  = 4,
   parameter int AW = (D > 1) ? $clog2(D) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [1:0]     act_sel,
   input  logic [M*N-1:0] bias,
   output logic           mem_rd,
   output logic [AW-1:0]  mem_addr,
   input  logic [N-1:0]   x_data,
   input  logic [M*N-1:0] w_data,
   output logic           busy,
   output logic           done,
   output logic [M*N-1:0] y
);

   state_t     state;
   logic       rd_q;
   logic [1:0] act_q;
   logic       load;
   logic       act_en;

   assign load   = (state == S_IDLE) && start;
   assign act_en = (state == S_ACT);

   // rd_q marks the cycle a memory read returns, which is when lanes accumulate.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         mem_rd   <= 1'b0;
         mem_addr <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rd_q     <= 1'b0;
         act_q    <= ACT_ID;
      end else begin
         rd_q <= mem_rd;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_FETCH;
                  mem_rd   <= 1'b1;
                  mem_addr <= '0;
                  busy     <= 1'b1;
                  act_q    <= act_sel;
               end
            end
            S_FETCH: begin
               if (mem_addr == AW'(D - 1)) begin
                  state    <= S_DRAIN;
                  mem_rd   <= 1'b0;
                  mem_addr <= '0;
               end else begin
                  mem_addr <= mem_addr + AW'(1);
               end
            end
            S_DRAIN: state <= S_ACT;
            S_ACT: begin
               state <= S_DONE;
               done  <= 1'b1;
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   for (genvar m = 0; m < M; m++) begin : g_lane
      neuron_mac_lane #(
         .N(N),
         .F(F),
         .D(D)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .load    (load),
         .acc_en  (rd_q),
         .act_en  (act_en),
         .act_sel (act_q),
         .bias_in (bias[m*N +: N]),
         .x_data  (x_data),
         .w_data  (w_data[m*N +: N]),
         .y       (y[m*N +: N])
      );
   end

endmodule
